// File: rtl/rv_configs.sv
// Shared configuration for the register file with scoreboard: default data width
// and the init/run FSM state encoding.
package rv_configs;

    localparam int RV_XLEN_DEFAULT = 32;

    typedef enum logic {
        RF_ST_INIT = 1'b0,
        RF_ST_RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rv_regfile_sb_rdport.sv
// One read port: array mux, writeback bypass compare and busy select.
// Bypass logic exists only when RV_REGFILE_BYPASS_EN is defined.
module rv_regfile_sb_rdport #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]        i_ra,
    input  logic [NREG*XLEN-1:0] i_regs,
    input  logic [NREG-1:0]      i_busy,
    input  logic                 i_run,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_wa,
    input  logic [XLEN-1:0]      i_wd,
    input  logic                 i_iss_hit,
    output logic [XLEN-1:0]      o_rd,
    output logic                 o_busy
);

    logic [XLEN-1:0] arr_data;

    assign arr_data = i_regs[int'(i_ra)*XLEN +: XLEN];

    // x0 and the whole init sweep are masked to zero / not busy.
    always_comb begin
        o_rd   = '0;
        o_busy = 1'b0;
        if (i_run && (i_ra != '0)) begin
            o_rd   = arr_data;
            o_busy = i_busy[i_ra];
`ifdef RV_REGFILE_BYPASS_EN
            if (i_we && (i_wa == i_ra)) begin
                o_rd   = i_wd;
                o_busy = i_iss_hit;
            end
`endif
        end
    end

`ifndef RV_REGFILE_BYPASS_EN
    logic unused_bypass_inputs;
    assign unused_bypass_inputs = ^{i_we, i_wa, i_wd, i_iss_hit};
`endif

endmodule

// File: rtl/rv_regfile_sb.sv
// Register file with per-register pending (scoreboard) bits and a zeroing init sweep.
// Define RV_REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module rv_regfile_sb
    import rv_configs::*;
#(
    parameter int XLEN = RV_XLEN_DEFAULT,
    parameter int NREG = 32,
    parameter int NRP  = 2
) (
    input  logic                        i_rf_clk,
    input  logic                        i_rf_rstn,
    input  logic [NRP*$clog2(NREG)-1:0] i_rf_ra,
    output logic [NRP*XLEN-1:0]         o_rf_rd,
    output logic [NRP-1:0]              o_rf_rbusy,
    input  logic                        i_rf_we,
    input  logic [$clog2(NREG)-1:0]     i_rf_wa,
    input  logic [XLEN-1:0]             i_rf_wd,
    input  logic                        i_rf_iss_v,
    input  logic [$clog2(NREG)-1:0]     i_rf_iss_a,
    input  logic                        i_rf_flush,
    output logic                        o_rf_ready
);

    localparam int AW = $clog2(NREG);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [XLEN-1:0] regs_q [NREG];

    logic                 run;
    logic                 sweep_we;
    logic                 wb_en;
    logic                 iss_hit;
    logic [NREG*XLEN-1:0] regs_flat;

    assign run   = (state_q == RF_ST_RUN);
    assign wb_en = run && i_rf_we && (i_rf_wa != '0);
    // Issue to the register being written back keeps it pending unless a flush kills the issue.
    assign iss_hit = i_rf_iss_v && !i_rf_flush && (i_rf_iss_a == i_rf_wa);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        sweep_we = 1'b0;
        case (state_q)
            RF_ST_INIT: begin
                sweep_we = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = RF_ST_RUN;
                    ready_d = 1'b1;
                end
            end
            RF_ST_RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = RF_ST_INIT;
                ready_d = 1'b0;
            end
        endcase
    end

    // Clear from writeback first, then set from issue, so a same-cycle issue wins.
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            if (wb_en) begin
                busy_d[i_rf_wa] = 1'b0;
            end
            if (i_rf_flush) begin
                busy_d = '0;
            end else if (i_rf_iss_v && (i_rf_iss_a != '0)) begin
                busy_d[i_rf_iss_a] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_rf_clk or negedge i_rf_rstn) begin
        if (!i_rf_rstn) begin
            state_q <= RF_ST_INIT;
            cnt_q   <= AW'(1);
            ready_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Data array carries no reset; the sweep defines its contents before RUN.
    always_ff @(posedge i_rf_clk) begin
        if (sweep_we) begin
            regs_q[cnt_q] <= '0;
        end else if (wb_en) begin
            regs_q[i_rf_wa] <= i_rf_wd;
        end
    end

    assign o_rf_ready = ready_q;

    for (genvar r = 0; r < NREG; r++) begin : g_flat
        assign regs_flat[r*XLEN +: XLEN] = regs_q[r];
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rdport
        rv_regfile_sb_rdport #(
            .XLEN(XLEN),
            .NREG(NREG),
            .AW  (AW)
        ) u_rdport (
            .i_ra     (i_rf_ra[p*AW +: AW]),
            .i_regs   (regs_flat),
            .i_busy   (busy_q),
            .i_run    (run),
            .i_we     (i_rf_we),
            .i_wa     (i_rf_wa),
            .i_wd     (i_rf_wd),
            .i_iss_hit(iss_hit),
            .o_rd     (o_rf_rd[p*XLEN +: XLEN]),
            .o_busy   (o_rf_rbusy[p])
        );
    end

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Scoreboard bench for rv_regfile_sb (NREG=32, NRP=2, XLEN=32); expectations follow
// RV_REGFILE_BYPASS_EN when it is defined for the build.
module tb_rv_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int AW   = 5;

`ifdef RV_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk;
    logic                 rstn;
    logic [NRP*AW-1:0]    ra;
    logic [NRP*XLEN-1:0]  rd;
    logic [NRP-1:0]       rbusy;
    logic                 we;
    logic [AW-1:0]        wa;
    logic [XLEN-1:0]      wd;
    logic                 iss_v;
    logic [AW-1:0]        iss_a;
    logic                 flush;
    logic                 ready;

    rv_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
        .i_rf_clk  (clk),
        .i_rf_rstn (rstn),
        .i_rf_ra   (ra),
        .o_rf_rd   (rd),
        .o_rf_rbusy(rbusy),
        .i_rf_we   (we),
        .i_rf_wa   (wa),
        .i_rf_wd   (wd),
        .i_rf_iss_v(iss_v),
        .i_rf_iss_a(iss_a),
        .i_rf_flush(flush),
        .o_rf_ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;   // 0 read data, 1 busy, 2 ready
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (expq.size() > 0) begin
                e = expq.pop_front();
                case (e.kind)
                    0:       act = rd[e.port*XLEN +: XLEN];
                    1:       act = {31'b0, rbusy[e.port]};
                    default: act = {31'b0, ready};
                endcase
                n_checks++;
                if (act !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "timeout");
    end

    task automatic push(input string name, input int kind, input int port, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.kind = kind; e.port = port; e.exp = exp;
        expq.push_back(e);
    endtask

    task automatic exp_rd(input string n, input int p, input logic [31:0] v);
        push(n, 0, p, v);
    endtask

    task automatic exp_busy(input string n, input int p, input logic v);
        push(n, 1, p, {31'b0, v});
    endtask

    task automatic exp_ready(input string n, input logic v);
        push(n, 2, 0, {31'b0, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; iss_v = 1'b0; flush = 1'b0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [31:0] d);
        we = 1'b1; wa = a; wd = d;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        iss_v = 1'b1; iss_a = a;
    endtask

    // Releases reset and runs the sweep, expecting ready exactly 31 edges later.
    // Writes/issues/flushes are held active throughout INIT and must be ignored.
    task automatic sweep(input string tag);
        rstn = 1'b1;
        for (int i = 1; i <= NREG - 1; i++) begin
            write(5'd5, 32'hFFFF_FFFF); issue(5'd6); flush = (i % 2 == 0);
            set_ra(5'd5, 5'd6);
            step();
            if (i < NREG - 1) begin
                if (i == 1 || i == 15 || i == NREG - 2) begin
                    exp_ready({tag, " ready low in INIT"}, 1'b0);
                    exp_rd({tag, " rd masked in INIT"}, 0, 32'h0);
                    exp_busy({tag, " busy masked in INIT"}, 1, 1'b0);
                end
            end else begin
                idle();
                exp_ready({tag, " ready after 31"}, 1'b1);
            end
        end
    endtask

    initial begin : stim
        rstn = 1'b0; idle(); wa = '0; wd = '0; iss_a = '0; set_ra(5'd0, 5'd0);
        step(); step();
        exp_ready("reset ready", 1'b0);
        exp_rd("reset rd0", 0, 32'h0);
        exp_busy("reset busy0", 0, 1'b0);
        step();

        sweep("first");
        n_checks++;
        if (ready !== 1'b1) begin
            n_errors++;
            $display("FAIL first sweep ready direct: got %b", ready);
        end
        step();
        exp_rd("init write ignored x5", 0, 32'h0);
        exp_busy("init issue ignored x6", 1, 1'b0);
        for (int a = 1; a < NREG; a += 2) begin
            set_ra(AW'(a), AW'(a + 1 < NREG ? a + 1 : 0));
            #1;
            exp_rd("swept reg p0", 0, 32'h0);
            exp_rd("swept reg p1", 1, 32'h0);
            step();
        end

        // Write x5 and read back; x0 stays zero.
        set_ra(5'd5, 5'd0); write(5'd5, 32'hDEAD_BEEF);
        #1;
        exp_rd("x5 same cycle", 0, BYP ? 32'hDEAD_BEEF : 32'h0);
        step(); idle();
        exp_rd("x5 next cycle", 0, 32'hDEAD_BEEF);
        n_checks++;
        if (rd[XLEN-1:0] !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL x5 next cycle direct: got %h", rd[XLEN-1:0]);
        end
        step();
        set_ra(5'd0, 5'd0); write(5'd0, 32'h1234);
        step(); idle();
        exp_rd("x0 after write", 0, 32'h0);
        exp_busy("x0 never busy", 0, 1'b0);
        issue(5'd0);
        step(); idle();
        exp_busy("x0 issue ignored", 0, 1'b0);
        step();

        // Issue x7, then writeback clears busy.
        set_ra(5'd7, 5'd0); issue(5'd7);
        #1;
        exp_busy("x7 busy before edge", 0, 1'b0);
        step(); idle();
        exp_busy("x7 busy after issue", 0, 1'b1);
        write(5'd7, 32'h55);
        #1;
        exp_busy("x7 wb same cycle busy", 0, BYP ? 1'b0 : 1'b1);
        exp_rd("x7 wb same cycle rd", 0, BYP ? 32'h55 : 32'h0);
        step(); idle();
        exp_busy("x7 busy cleared", 0, 1'b0);
        exp_rd("x7 data", 0, 32'h55);
        n_checks++;
        if (rbusy[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL x7 busy cleared direct: got %b", rbusy[0]);
        end
        step();

        // Same-cycle issue and writeback: data written, issue wins busy.
        set_ra(5'd3, 5'd0); issue(5'd3); write(5'd3, 32'hA5);
        #1;
        exp_rd("x3 iss+wb same rd", 0, BYP ? 32'hA5 : 32'h0);
        exp_busy("x3 iss+wb same busy", 0, BYP ? 1'b1 : 1'b0);
        step(); idle();
        exp_rd("x3 data", 0, 32'hA5);
        exp_busy("x3 busy kept", 0, 1'b1);
        issue(5'd8);
        step(); idle();
        set_ra(5'd4, 5'd8);
        #1;
        exp_busy("x8 busy", 1, 1'b1);
        flush = 1'b1; issue(5'd4); write(5'd10, 32'h10);
        #1;
        exp_busy("x8 busy during flush", 1, 1'b1);
        step(); idle();
        exp_busy("flush drops issue x4", 0, 1'b0);
        exp_busy("flush clears x8", 1, 1'b0);
        set_ra(5'd3, 5'd10);
        #1;
        exp_busy("flush clears x3", 0, 1'b0);
        exp_rd("write during flush x10", 1, 32'h10);
        step();

        // Two ports on the same register.
        issue(5'd5);
        step(); idle();
        set_ra(5'd5, 5'd5);
        #1;
        exp_rd("dual port rd p0", 0, 32'hDEAD_BEEF);
        exp_rd("dual port rd p1", 1, 32'hDEAD_BEEF);
        exp_busy("dual port busy p0", 0, 1'b1);
        exp_busy("dual port busy p1", 1, 1'b1);
        step();

        // Port 1 read of x9 during its writeback.
        set_ra(5'd0, 5'd9); write(5'd9, 32'h77);
        #1;
        exp_rd("x9 same cycle p1", 1, BYP ? 32'h77 : 32'h0);
        step(); idle();
        exp_rd("x9 next cycle p1", 1, 32'h77);
        issue(5'd12);
        step(); idle();

        // Asynchronous reset mid-operation, then pulsed again mid-sweep.
        rstn = 1'b0;
        set_ra(5'd5, 5'd12);
        #1;
        exp_ready("async reset ready", 1'b0);
        exp_rd("async reset rd", 0, 32'h0);
        exp_busy("async reset busy", 1, 1'b0);
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL async reset ready direct: got %b", ready);
        end
        step(); step();
        rstn = 1'b1;
        for (int i = 1; i <= 9; i++) step();
        exp_ready("mid-sweep ready low", 1'b0);
        rstn = 1'b0;
        step();
        sweep("second");
        n_checks++;
        if (ready !== 1'b1) begin
            n_errors++;
            $display("FAIL second sweep ready direct: got %b", ready);
        end
        step();
        set_ra(5'd5, 5'd12);
        #1;
        exp_rd("x5 cleared by resweep", 0, 32'h0);
        exp_busy("x12 busy cleared", 1, 1'b0);
        step();

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_regfile_sb.md
RV_REGFILE_SB -- requirements
Module: rv_regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width per register.
REQ-002 SHALL have parameter NREG, default 32, meaning register count (power of two, >=4); AW = clog2(NREG).
REQ-003 SHALL have parameter NRP, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have port i_rf_clk  in  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port i_rf_rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_rf_ra  in  NRP*AW  packed read addresses; port p in bits [p*AW +: AW].
REQ-007 SHALL have port o_rf_rd  out  NRP*XLEN  packed read data, same packing.
REQ-008 SHALL have port o_rf_rbusy  out  NRP  per-port scoreboard busy flag of the addressed register.
REQ-009 SHALL have ports i_rf_we (1), i_rf_wa (AW), i_rf_wd (XLEN)  in  writeback enable, address, data.
REQ-010 SHALL have ports i_rf_iss_v (1), i_rf_iss_a (AW)  in  issue: mark destination register pending.
REQ-011 SHALL have port i_rf_flush  in  1  clear all pending marks.
REQ-012 SHALL have port o_rf_ready  out  1  high once the init sweep completes.

Function
REQ-013 SHALL implement a two-state FSM: INIT and RUN.
REQ-014 In INIT, a sweep counter SHALL write zero to registers 1..NREG-1, one per cycle, then enter RUN; total INIT duration is NREG-1 cycles after reset release.
REQ-015 In INIT, writes, issues and flushes SHALL be ignored; o_rf_rd SHALL read 0 and o_rf_rbusy 0.
REQ-016 o_rf_ready SHALL be 0 in INIT and 1 in RUN, registered.
REQ-017 Reads SHALL be combinational from the array: o_rf_rd[p] = reg[ra[p]].
REQ-018 Register 0 SHALL always read 0, ignore writes, and never be busy.
REQ-019 Writeback with i_rf_we=1 SHALL update reg[i_rf_wa] at the posedge and clear busy[i_rf_wa].
REQ-020 Issue with i_rf_iss_v=1 SHALL set busy[i_rf_iss_a] at the posedge.
REQ-021 Issue and writeback to the same nonzero register in one cycle SHALL write the data and leave busy set (issue wins: new producer).
REQ-022 i_rf_flush=1 SHALL clear all busy bits; a same-cycle issue SHALL be ignored (flush wins); a same-cycle write still updates data.
REQ-023 Several read ports with the same address SHALL return identical data and busy.

Reset
REQ-024 Asserting i_rf_rstn low SHALL asynchronously force state INIT, sweep counter 1, all busy bits 0, o_rf_ready 0.
REQ-025 Reset asserted mid-sweep or mid-operation SHALL restart the full sweep after release.
REQ-026 Array contents are undefined until the sweep completes; outputs are masked per REQ-015.

Configuration
REQ-027 Macro RV_REGFILE_BYPASS_EN defined: a read address equal to nonzero i_rf_wa with i_rf_we=1 in RUN SHALL return i_rf_wd and o_rf_rbusy=0 in the same cycle (unless REQ-021 issue hit, then busy=1).
REQ-028 Macro RV_REGFILE_BYPASS_EN undefined: same-cycle reads SHALL return the old value and old busy; the new value is visible the following cycle.

Structure
REQ-029 Shared package rv_configs SHALL hold XLEN default and FSM state encoding constants (RF_ST_INIT=0, RF_ST_RUN=1).
REQ-030 One sub-module rv_regfile_sb_rdport (address mux + bypass compare + busy select) SHALL be instantiated NRP times via generate.
REQ-031 The array and scoreboard SHALL remain in the top module.

Verification
REQ-032 Reset release, NREG=32 -> o_rf_ready rises exactly 31 cycles later; all reads return 0.
REQ-033 In RUN write x5=0xDEADBEEF, next cycle read ra[0]=5 -> 0xDEADBEEF; write x0=0x1234 -> x0 reads 0.
REQ-034 Issue x7; next cycle rbusy for x7=1; writeback x7=0x55 -> busy 0 next cycle (same cycle with BYPASS_EN).
REQ-035 Same cycle issue x3 and write x3=0xA5 -> x3 reads 0xA5, busy stays 1; flush plus issue x4 -> all busy 0.
REQ-036 Write x9=0x77 while ra[1]=9 -> with BYPASS_EN rd[1]=0x77 same cycle; without it old value, 0x77 next cycle.
REQ-037 Reset pulsed at sweep count 10 -> o_rf_ready stays 0, rises 31 cycles after second release.
